fwd_hazard_unit: RTL and testbench

Parametrised operand bypass and interlock unit for the EX stage. It generalises two-stage MEM/WB forwarding to `NSRC` source operands and `NSTG` producer stages with strict youngest-first priority. It adds three things: a load-use stall state machine, a one-entry write-back shadow register that covers the register-file write/read window, and stall statistics. It sits between the ID/EX pipeline register and the ALU operand muxes, and drives the global hold for IF/ID/EX.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_sel_prio.sv | 67 ++++++
 rtl/fwd_hazard_unit.sv | 122 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand bypass / interlock unit.
package fwd_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fsm_state_e;

  // Operand source: producer stage number, shadow register, or register file.
  typedef logic [3:0] src_sel_t;
  localparam src_sel_t SRC_STG0   = 4'h0;
  localparam src_sel_t SRC_SHADOW = 4'hE;
  localparam src_sel_t SRC_RF     = 4'hF;

  function automatic src_sel_t src_stg(input int k);
    return src_sel_t'(k);
  endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Per-operand youngest-first match across producer stages, shadow and RF fallback.
module fwd_sel_prio
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSTG = 2
) (
  input  logic [REG_IDX_W-1:0]      rs_idx,
  input  logic                      rs_en,
  input  logic [XLEN-1:0]           rs_data,
  input  logic [NSTG*REG_IDX_W-1:0] stg_rd_idx,
  input  logic [NSTG-1:0]           stg_rd_en,
  input  logic [NSTG-1:0]           stg_rd_rdy,
  input  logic [NSTG*XLEN-1:0]      stg_rd_data,
  input  logic                      sh_valid,
  input  logic [REG_IDX_W-1:0]      sh_idx,
  input  logic [XLEN-1:0]           sh_data,
  output logic [XLEN-1:0]           op,
  output logic                      hazard,
  output src_sel_t                  src_sel
);

  logic [NSTG-1:0] match;
  logic            found;
  logic            win_rdy;
  logic [XLEN-1:0] win_data;
  src_sel_t        win_sel;

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      match[k] = rs_en & stg_rd_en[k] & (rs_idx != '0) &
                 (rs_idx == stg_rd_idx[k*REG_IDX_W +: REG_IDX_W]);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; only one stage is ever selected.
  always_comb begin
    found    = 1'b0;
    win_rdy  = 1'b0;
    win_data = '0;
    win_sel  = SRC_RF;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (match[k]) begin
        found    = 1'b1;
        win_rdy  = stg_rd_rdy[k];
        win_data = stg_rd_data[k*XLEN +: XLEN];
        win_sel  = src_stg(k);
      end
    end

    op      = rs_data;
    hazard  = 1'b0;
    src_sel = SRC_RF;
    if (found) begin
      src_sel = win_sel;
      if (win_rdy) begin
        op = win_data;
      end else begin
        hazard = 1'b1;
      end
    end else if (rs_en && sh_valid && (sh_idx == rs_idx)) begin
      op      = sh_data;
      src_sel = SRC_SHADOW;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass, load-use interlock FSM, write-back shadow register and stall statistics.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC*REG_IDX_W-1:0] ex_rs_idx,
  input  logic [NSRC-1:0]           ex_rs_en,
  input  logic [NSRC*XLEN-1:0]      ex_rs_data,
  input  logic [NSTG*REG_IDX_W-1:0] stg_rd_idx,
  input  logic [NSTG-1:0]           stg_rd_en,
  input  logic [NSTG-1:0]           stg_rd_rdy,
  input  logic [NSTG*XLEN-1:0]      stg_rd_data,
  output logic [NSRC*XLEN-1:0]      op_rs,
  output logic                      stall,
  output logic                      err_timeout,
  output logic [31:0]               stall_cnt
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_WAIT = WAIT;
  localparam int         WCW     = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam int         OLD     = NSTG - 1;

  logic                 sh_valid_q, sh_valid_d;
  logic [REG_IDX_W-1:0] sh_idx_q, sh_idx_d;
  logic [XLEN-1:0]      sh_data_q, sh_data_d;
  logic [0:0]           state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]      hazard;
  src_sel_t             src_sel [NSRC];

  // The oldest stage is the register-file writer; hold its write for one cycle.
  always_comb begin
    sh_idx_d   = stg_rd_idx[OLD*REG_IDX_W +: REG_IDX_W];
    sh_data_d  = stg_rd_data[OLD*XLEN +: XLEN];
    sh_valid_d = stg_rd_en[OLD] & stg_rd_rdy[OLD] & (sh_idx_d != '0);
  end

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      fwd_sel_prio #(
        .XLEN (XLEN),
        .NSTG (NSTG)
      ) u_sel (
        .rs_idx      (ex_rs_idx[gi*REG_IDX_W +: REG_IDX_W]),
        .rs_en       (ex_rs_en[gi]),
        .rs_data     (ex_rs_data[gi*XLEN +: XLEN]),
        .stg_rd_idx  (stg_rd_idx),
        .stg_rd_en   (stg_rd_en),
        .stg_rd_rdy  (stg_rd_rdy),
        .stg_rd_data (stg_rd_data),
        .sh_valid    (sh_valid_q),
        .sh_idx      (sh_idx_q),
        .sh_data     (sh_data_q),
        .op          (op_rs[gi*XLEN +: XLEN]),
        .hazard      (hazard[gi]),
        .src_sel     (src_sel[gi])
      );

      always_comb begin
        assert (!hazard[gi] || (src_sel[gi] < src_stg(NSTG)));
      end
    end
  endgenerate

  assign stall       = |hazard;
  assign err_timeout = err_q;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      default: begin
        if (stall) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
    endcase
    err_d       = err_q | (stall & (wait_cnt_d == WAIT_MAX));
    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid_q  <= 1'b0;
      sh_idx_q    <= '0;
      sh_data_q   <= '0;
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sh_valid_q  <= sh_valid_d;
      sh_idx_q    <= sh_idx_d;
      sh_data_q   <= sh_data_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vectors with a scoreboard queue; a negedge monitor pops and compares.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration: 2 sources, 2 stages
  logic [9:0]  a_rs_idx;
  logic [1:0]  a_rs_en;
  logic [63:0] a_rs_data;
  logic [9:0]  a_stg_idx;
  logic [1:0]  a_stg_en, a_stg_rdy;
  logic [63:0] a_stg_data;
  logic [63:0] a_op;
  logic        a_stall, a_err;
  logic [31:0] a_cnt;

  // Wide configuration: 3 sources, 3 stages
  logic [14:0] b_rs_idx;
  logic [2:0]  b_rs_en;
  logic [95:0] b_rs_data;
  logic [14:0] b_stg_idx;
  logic [2:0]  b_stg_en, b_stg_rdy;
  logic [95:0] b_stg_data;
  logic [95:0] b_op;
  logic        b_stall, b_err;
  logic [31:0] b_cnt;

  fwd_hazard_unit #(.XLEN(32), .NSRC(2), .NSTG(2), .MAX_WAIT(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .ex_rs_idx(a_rs_idx), .ex_rs_en(a_rs_en), .ex_rs_data(a_rs_data),
    .stg_rd_idx(a_stg_idx), .stg_rd_en(a_stg_en), .stg_rd_rdy(a_stg_rdy), .stg_rd_data(a_stg_data),
    .op_rs(a_op), .stall(a_stall), .err_timeout(a_err), .stall_cnt(a_cnt)
  );

  fwd_hazard_unit #(.XLEN(32), .NSRC(3), .NSTG(3), .MAX_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .ex_rs_idx(b_rs_idx), .ex_rs_en(b_rs_en), .ex_rs_data(b_rs_data),
    .stg_rd_idx(b_stg_idx), .stg_rd_en(b_stg_en), .stg_rd_rdy(b_stg_rdy), .stg_rd_data(b_stg_data),
    .op_rs(b_op), .stall(b_stall), .err_timeout(b_err), .stall_cnt(b_cnt)
  );

  typedef struct packed {
    int          id;
    bit          dut_b;
    bit [2:0]    m_op;
    logic [31:0] op0, op1, op2;
    bit          c_stall, stall;
    bit          c_err, err;
    bit          c_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL v%0d %s: got 0x%08h expected 0x%08h", id, what, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is a response.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [95:0] ops;
      logic        st, er;
      logic [31:0] cn;
      e   = sb.pop_front();
      ops = e.dut_b ? b_op : {32'h0, a_op};
      st  = e.dut_b ? b_stall : a_stall;
      er  = e.dut_b ? b_err : a_err;
      cn  = e.dut_b ? b_cnt : a_cnt;
      if (e.m_op[0]) chk(e.id, "op0", ops[31:0], e.op0);
      if (e.m_op[1]) chk(e.id, "op1", ops[63:32], e.op1);
      if (e.m_op[2]) chk(e.id, "op2", ops[95:64], e.op2);
      if (e.c_stall) chk(e.id, "stall", {31'h0, st}, {31'h0, e.stall});
      if (e.c_err)   chk(e.id, "err_timeout", {31'h0, er}, {31'h0, e.err});
      if (e.c_cnt)   chk(e.id, "stall_cnt", cn, e.cnt);
      $display("[TB] v%0d dut=%s op=%h stall=%0b err=%0b cnt=%0d",
               e.id, e.dut_b ? "B" : "A", ops, st, er, cn);
    end
  end

  // st/er/cn < 0 means "do not check"
  task automatic push(input int id, input bit b, input bit [2:0] m,
                      input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                      input int st, input int er, input longint cn);
    exp_t e;
    e.id = id; e.dut_b = b; e.m_op = m;
    e.op0 = o0; e.op1 = o1; e.op2 = o2;
    e.c_stall = (st >= 0); e.stall = (st == 1);
    e.c_err   = (er >= 0); e.err   = (er == 1);
    e.c_cnt   = (cn >= 0); e.cnt   = cn[31:0];
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clear();
    a_rs_idx = '0; a_rs_en = '0; a_rs_data = '0;
    a_stg_idx = '0; a_stg_en = '0; a_stg_rdy = '0; a_stg_data = '0;
  endtask

  task automatic b_clear();
    b_rs_idx = '0; b_rs_en = '0; b_rs_data = '0;
    b_stg_idx = '0; b_stg_en = '0; b_stg_rdy = '0; b_stg_data = '0;
  endtask

  task automatic a_src(input int i, input logic [4:0] idx, input logic [31:0] d);
    a_rs_idx[i*5 +: 5] = idx; a_rs_en[i] = 1'b1; a_rs_data[i*32 +: 32] = d;
  endtask

  task automatic a_stg(input int k, input logic [4:0] idx, input logic rdy, input logic [31:0] d);
    a_stg_idx[k*5 +: 5] = idx; a_stg_en[k] = 1'b1; a_stg_rdy[k] = rdy; a_stg_data[k*32 +: 32] = d;
  endtask

  task automatic b_src(input int i, input logic [4:0] idx, input logic [31:0] d);
    b_rs_idx[i*5 +: 5] = idx; b_rs_en[i] = 1'b1; b_rs_data[i*32 +: 32] = d;
  endtask

  task automatic b_stg(input int k, input logic [4:0] idx, input logic rdy, input logic [31:0] d);
    b_stg_idx[k*5 +: 5] = idx; b_stg_en[k] = 1'b1; b_stg_rdy[k] = rdy; b_stg_data[k*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_clear();
    b_clear();
    step();

    // Reset state
    a_src(0, 5'd3, 32'h1111);
    push(0, 0, 3'b001, 32'h1111, 0, 0, 0, 0, 0); step();
    rst = 1'b0;

    // Youngest-first priority
    a_clear(); a_stg(0, 5'd5, 1, 32'hAAAA_AAAA); a_stg(1, 5'd5, 1, 32'h5555_5555);
    a_src(0, 5'd5, 0); a_src(1, 5'd6, 32'h66);
    push(1, 0, 3'b011, 32'hAAAA_AAAA, 32'h66, 0, 0, -1, 0); step();

    // x0 never forwarded; op1 picks up last cycle's WB write of x5 from the shadow
    a_clear(); a_stg(0, 5'd0, 1, 32'h1234); a_src(0, 5'd0, 0); a_src(1, 5'd5, 32'h99);
    push(2, 0, 3'b011, 0, 32'h5555_5555, 0, 0, -1, -1); step();

    // Load-use: two not-ready cycles, then data arrives
    a_clear(); a_stg(0, 5'd7, 0, 32'hBAD); a_src(0, 5'd7, 0); a_src(1, 5'd8, 32'h88);
    push(3, 0, 3'b010, 0, 32'h88, 0, 1, 0, 0); step();
    push(4, 0, 3'b010, 0, 32'h88, 0, 1, 0, 1); step();
    a_stg(0, 5'd7, 1, 32'hDEAD);
    push(5, 0, 3'b011, 32'hDEAD, 32'h88, 0, 0, 0, 2); step();
    a_clear(); a_src(0, 5'd7, 32'h70);
    push(6, 0, 3'b001, 32'h70, 0, 0, 0, -1, 2); step();

    // Shadow window: visible at t+1 only
    a_clear(); a_stg(1, 5'd9, 1, 32'h77); a_src(0, 5'd3, 32'h33);
    push(7, 0, 3'b001, 32'h33, 0, 0, 0, -1, 2); step();
    a_clear(); a_src(0, 5'd9, 0); a_src(1, 5'd1, 32'h11);
    push(8, 0, 3'b011, 32'h77, 32'h11, 0, 0, -1, 2); step();
    a_clear(); a_src(0, 5'd9, 0);
    push(9, 0, 3'b001, 0, 0, 0, 0, -1, 2); step();

    // Timeout after MAX_WAIT stalled cycles, sticky afterwards
    for (int c = 0; c < 4; c++) begin
      a_clear(); a_stg(0, 5'd4, 0, 32'h44); a_src(1, 5'd4, 0);
      push(10 + c, 0, 3'b000, 0, 0, 0, 1, 0, 2 + c); step();
    end
    a_clear();
    push(14, 0, 3'b000, 0, 0, 0, 0, 1, 6); step();
    push(15, 0, 3'b000, 0, 0, 0, 0, 1, 6); step();

    // Reset mid-stall with the hazard still present
    rst = 1'b1; a_stg(0, 5'd4, 0, 32'h44); a_src(1, 5'd4, 0);
    push(16, 0, 3'b000, 0, 0, 0, 1, 1, 6); step();
    rst = 1'b0;
    push(17, 0, 3'b000, 0, 0, 0, 1, 0, 0); step();
    push(18, 0, 3'b000, 0, 0, 0, 1, 0, 1); step();
    a_clear();
    push(19, 0, 3'b000, 0, 0, 0, 0, 0, 2); step();

    // Young not-ready + old ready on same register: stall, no fallback to old stage
    a_stg(0, 5'd10, 0, 0); a_stg(1, 5'd10, 1, 32'h1010); a_src(0, 5'd10, 0);
    push(20, 0, 3'b000, 0, 0, 0, 1, -1, 2); step();
    a_clear(); a_src(0, 5'd10, 32'hAB);
    push(21, 0, 3'b001, 32'h1010, 0, 0, 0, -1, 3); step();

    // Wide configuration: independent per-operand selection
    b_clear();
    b_stg(0, 5'd1, 1, 32'hA0); b_stg(1, 5'd2, 1, 32'hB1); b_stg(2, 5'd3, 1, 32'hC2);
    b_src(0, 5'd1, 32'h100); b_src(1, 5'd2, 32'h101); b_src(2, 5'd3, 32'h102);
    push(22, 1, 3'b111, 32'hA0, 32'hB1, 32'hC2, 0, -1, 0); step();
    b_stg(0, 5'd2, 1, 32'hD0); b_stg(1, 5'd3, 1, 32'hE1); b_stg(2, 5'd1, 1, 32'hF2);
    push(23, 1, 3'b111, 32'hF2, 32'hD0, 32'hE1, 0, -1, 0); step();
    b_clear();
    b_stg(0, 5'd3, 1, 32'h30); b_stg(1, 5'd3, 0, 32'h31); b_stg(2, 5'd3, 1, 32'h32);
    b_src(0, 5'd3, 1); b_src(1, 5'd3, 2); b_src(2, 5'd3, 3);
    push(24, 1, 3'b111, 32'h30, 32'h30, 32'h30, 0, -1, 0); step();
    b_clear();
    b_stg(0, 5'd5, 0, 32'h50); b_stg(1, 5'd6, 1, 32'h61);
    b_src(0, 5'd5, 1); b_src(1, 5'd6, 2); b_src(2, 5'd0, 0);
    push(25, 1, 3'b110, 0, 32'h61, 0, 1, -1, 0); step();
    b_clear();

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
